overdrive_pipe: RTL and testbench
=================================

OVERDRIVE_PIPE -- requirements
Module: overdrive_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample width, signed two's complement.
REQ-002 SHALL have parameter FRAC_W, default 12, meaning fractional bits; One = 2**FRAC_W.
REQ-003 SHALL have parameter GAIN_W, default 16, meaning unsigned gain width with FRAC_W fractional bits.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_sample is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port in_sample, input, DATA_W bits: signed input sample.
REQ-009 SHALL have port gain, input, GAIN_W bits: pre-gain, sampled with the beat.
REQ-010 SHALL have port mode, input, 1 bit: 0 selects soft clip, 1 selects hard clip; sampled with the beat.
REQ-011 SHALL have port ou_valid, output, 1 bit: ou_sample is valid.
REQ-012 SHALL have port ou_ready, input, 1 bit: the downstream block accepts.
REQ-013 SHALL have port ou_sample, output, DATA_W bits: shaped signed sample.

Function
REQ-014 SHALL accept a beat when in_valid and in_ready are both high, and SHALL emit it when ou_valid and ou_ready are both high.
REQ-015 SHALL be a 3-stage pipeline: S1 applies gain, S2 forms the square, S3 forms the cube and the output.
REQ-016 SHALL advance all stages together when (ou_ready or not ou_valid); in_ready SHALL equal that advance term.
REQ-017 SHALL have a latency of exactly 3 cycles from acceptance to ou_valid when not stalled, and SHALL sustain 1 beat per cycle.
REQ-018 SHALL hold all stage contents and ou_sample stable while stalled, with no beat lost or duplicated.
REQ-019 S1 SHALL compute g = (in_sample * gain) / One, truncated toward zero, in full precision.
REQ-020 S1 SHALL saturate g to the DATA_W signed range.
REQ-021 In soft mode with |g| < One, the output SHALL be (3*g - c) / 2, truncated toward zero.
REQ-022 In the soft-mode formula, c = mul(mul(g,g),g), where mul(a,b) = a*b/One, truncated toward zero.
REQ-023 In soft mode, g >= One SHALL give +One and g <= -One SHALL give -One.
REQ-024 In hard mode, the output SHALL be g clamped to the range [-One, +One].
REQ-025 Intermediate products SHALL be at least 2*DATA_W bits wide, so that no wrap-around occurs before saturation.
REQ-026 mode and gain SHALL travel with their beat, so changing them mid-stream affects only beats accepted afterwards.
REQ-027 Simultaneous acceptance and emission SHALL both occur in the same cycle.

Reset
REQ-028 While rst_n is low, all stage valid bits, ou_valid and ou_sample SHALL be 0; in_ready SHALL be 1 after reset release.
REQ-029 Asserting reset mid-operation SHALL discard all in-flight beats; the first beat accepted after release SHALL appear after 3 cycles.

Configuration
REQ-030 With macro OVERDRIVE_CLIP_COUNT_EN defined, the block SHALL add two ports: clip_clr (input, 1 bit) and clip_count (output, 16 bits).
REQ-031 With OVERDRIVE_CLIP_COUNT_EN defined, clip_count SHALL increment, saturating at 65535, on each emitted beat whose |g| >= One.
REQ-032 With OVERDRIVE_CLIP_COUNT_EN defined, clip_clr high SHALL zero clip_count, taking priority over increment; clip_count SHALL be 0 in reset.
REQ-033 Without OVERDRIVE_CLIP_COUNT_EN, clip_clr and clip_count SHALL be absent and the datapath SHALL be identical.

Verification
REQ-034 With defaults, gain=4096, mode=0, in_sample=2048 then -2048: the bench SHALL see ou_sample=2816 then -2816, first result 3 cycles after acceptance.
REQ-035 With gain=4096, mode=0, in_sample=5000 then -4096: the bench SHALL see +4096 then -4096.
REQ-036 With gain=4096, mode=1, in_sample=3000 then -9000: the bench SHALL see 3000 then -4096.
REQ-037 With gain=8192, mode=0, in_sample=3000: the bench SHALL see 4096; with in_sample=2**30 the bench SHALL see 4096 (S1 saturation, no wrap).
REQ-038 With 10 back-to-back beats and ou_ready held low for cycles 4-7: the bench SHALL see all 10 outputs in order, ou_sample stable while stalled, and in_ready low during the stall.
REQ-039 With OVERDRIVE_CLIP_COUNT_EN: 3 clipping beats and 2 non-clipping beats SHALL give clip_count=3; then clip_clr SHALL give 0; reset asserted mid-stream SHALL drop ou_valid to 0 immediately.

Source files
------------

// File: rtl/overdrive_pipe.sv
// Three-stage overdrive shaper: pre-gain, then soft (cubic) or hard clip to +/-One.
// Define OVERDRIVE_CLIP_COUNT_EN to add a saturating count of clipped output beats.
module overdrive_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 12,
  parameter int GAIN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic [GAIN_W-1:0] gain,
  input  logic              mode,
  output logic              ou_valid,
  input  logic              ou_ready,
`ifdef OVERDRIVE_CLIP_COUNT_EN
  input  logic              clip_clr,
  output logic [15:0]       clip_count,
`endif
  output logic [DATA_W-1:0] ou_sample
);

  // Wide enough for sample*gain and for g*g of a saturated g, so nothing wraps.
  localparam int PROD_W = (DATA_W + GAIN_W + 1 > 2 * DATA_W) ? DATA_W + GAIN_W + 1 : 2 * DATA_W;

  typedef logic signed [PROD_W-1:0] wide_t;
  typedef logic signed [DATA_W-1:0] data_t;

  localparam wide_t ONE   = wide_t'(1) << FRAC_W;
  localparam wide_t MAX_D = (wide_t'(1) << (DATA_W - 1)) - wide_t'(1);
  localparam wide_t MIN_D = -MAX_D - wide_t'(1);

  // Divide by One, truncating toward zero (a bare arithmetic shift would floor).
  function automatic wide_t div_one(input wide_t p);
    return (p + ((p < 0) ? (ONE - wide_t'(1)) : wide_t'(0))) >>> FRAC_W;
  endfunction

  function automatic wide_t div_two(input wide_t p);
    return (p + ((p < 0) ? wide_t'(1) : wide_t'(0))) >>> 1;
  endfunction

  logic  advance;
  logic  s1_valid, s1_mode, s2_valid, s2_mode;
  data_t s1_g, s2_g, s2_sq;

  wide_t prod1, g1_full, g1_sat, g2, g3, c3, shaped;
  logic  clip3;

  assign advance  = ou_ready || !ou_valid;
  assign in_ready = advance;

  // S1: full-precision gain product, scaled and saturated to the sample range.
  assign prod1   = wide_t'($signed(in_sample)) * wide_t'(gain);
  assign g1_full = div_one(prod1);
  assign g1_sat  = (g1_full > MAX_D) ? MAX_D : (g1_full < MIN_D) ? MIN_D : g1_full;

  assign g2 = wide_t'(s1_g);
  assign g3 = wide_t'(s2_g);
  assign c3 = div_one(wide_t'(s2_sq) * g3);

  // The square/cube only matter when |g| < One, where they fit in DATA_W.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    shaped = '0;
    clip3  = (g3 >= ONE) || (g3 <= -ONE);
    if (clip3)       shaped = g3[PROD_W-1] ? -ONE : ONE;
    else if (s2_mode) shaped = g3;
    else             shaped = div_two(wide_t'(3) * g3 - c3);
  end

`ifdef OVERDRIVE_CLIP_COUNT_EN
  logic ou_clip;
`endif

  // NOTE: data registers are reset along with valids so ou_sample reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= 1'b0;
      s1_g      <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= 1'b0;
      s2_g      <= '0;
      s2_sq     <= '0;
      ou_valid  <= 1'b0;
      ou_sample <= '0;
`ifdef OVERDRIVE_CLIP_COUNT_EN
      ou_clip   <= 1'b0;
`endif
    end else if (advance) begin
      // NOTE: non-blocking updates so every stage reads its predecessor's old value.
      s1_valid  <= in_valid;
      s1_mode   <= mode;
      s1_g      <= data_t'(g1_sat);
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_g      <= s1_g;
      s2_sq     <= data_t'(div_one(g2 * g2));
      ou_valid  <= s2_valid;
      ou_sample <= data_t'(shaped);
`ifdef OVERDRIVE_CLIP_COUNT_EN
      ou_clip   <= clip3;
`endif
    end
  end

`ifdef OVERDRIVE_CLIP_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clip_clr) begin
      clip_count <= '0;
    end else if (ou_valid && ou_ready && ou_clip && (clip_count != 16'hFFFF)) begin
      clip_count <= clip_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_overdrive_pipe.sv
// Directed bench for overdrive_pipe: latency, soft/hard shaping, S1 saturation,
// stall behaviour, mid-stream reset and (with OVERDRIVE_CLIP_COUNT_EN) the clip counter.
module tb_overdrive_pipe;
  localparam int DATA_W = 32;
  localparam int GAIN_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_sample = '0;
  logic [GAIN_W-1:0] gain = '0;
  logic              mode = 1'b0;
  logic              ou_valid;
  logic              ou_ready = 1'b1;
  logic [DATA_W-1:0] ou_sample;
`ifdef OVERDRIVE_CLIP_COUNT_EN
  logic              clip_clr = 1'b0;
  logic [15:0]       clip_count;
`endif

  int checks = 0;
  int errors = 0;

  int q_in[$];
  int q_gain[$];
  int q_exp[$];
  bit q_mode[$];

  overdrive_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .gain      (gain),
    .mode      (mode),
    .ou_valid  (ou_valid),
    .ou_ready  (ou_ready),
`ifdef OVERDRIVE_CLIP_COUNT_EN
    .clip_clr  (clip_clr),
    .clip_count(clip_count),
`endif
    .ou_sample (ou_sample)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input int g, input bit m, input int e);
    q_in.push_back(s);
    q_gain.push_back(g);
    q_mode.push_back(m);
    q_exp.push_back(e);
  endtask

  // Drive queued beats back-to-back; beat i must appear 3 cycles after it is offered.
  task automatic flush(input string tag);
    int n;
    n = q_in.size();
    for (int c = 0; c < n + 3; c++) begin
      if (c >= 3) begin
        check($sformatf("%s_valid[%0d]", tag, c - 3), ou_valid, 1);
        check($sformatf("%s_sample[%0d]", tag, c - 3), $signed(ou_sample), q_exp[c-3]);
      end else begin
        check($sformatf("%s_latency_c%0d", tag, c), ou_valid, 0);
      end
      if (c < n) begin
        in_valid  = 1'b1;
        in_sample = q_in[c];
        gain      = GAIN_W'(q_gain[c]);
        mode      = q_mode[c];
        check($sformatf("%s_in_ready[%0d]", tag, c), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    check({tag, "_drained"}, ou_valid, 0);
    q_in.delete();
    q_gain.delete();
    q_mode.delete();
    q_exp.delete();
  endtask

  initial begin
    int acc_idx;
    int out_idx;
    bit prev_stalled;
    logic [DATA_W-1:0] prev_sample;

    #12;
    check("reset_ou_valid", ou_valid, 0);
    check("reset_ou_sample", $signed(ou_sample), 0);
`ifdef OVERDRIVE_CLIP_COUNT_EN
    check("reset_clip_count", clip_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_reset_in_ready", in_ready, 1);

    push(2048, 4096, 0, 2816);
    push(-2048, 4096, 0, -2816);
    flush("soft_small");

    push(5000, 4096, 0, 4096);
    push(-4096, 4096, 0, -4096);
    flush("soft_clip");

    push(3000, 4096, 1, 3000);
    push(-9000, 4096, 1, -4096);
    flush("hard");

    push(3000, 8192, 0, 4096);
    push(1 << 30, 8192, 0, 4096);
    push(-(1 << 30), 8192, 1, -4096);
    flush("s1_sat");

    push(1000, 4096, 0, 1470);
    push(-1000, 4096, 0, -1470);
    push(-1, 2048, 1, 0);
    push(4095, 4096, 0, 4096);
    push(-4095, 4096, 0, -4096);
    flush("trunc");

    push(3000, 4096, 1, 3000);
    push(3000, 4096, 0, 3695);
    push(3000, 8192, 1, 4096);
    push(1000, 2048, 1, 500);
    flush("travel");

    // Ten back-to-back hard-mode beats with the output stalled in cycles 4-7.
    acc_idx = 0;
    out_idx = 0;
    prev_stalled = 1'b0;
    prev_sample = '0;
    gain = 16'd4096;
    mode = 1'b1;
    for (int c = 0; c < 40; c++) begin
      ou_ready = !(c >= 4 && c <= 7);
      if (acc_idx < 10) begin
        in_valid  = 1'b1;
        in_sample = (acc_idx + 1) * 100;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 4 && c <= 7) check($sformatf("stall_in_ready_c%0d", c), in_ready, 0);
      if (prev_stalled) check($sformatf("stall_hold_c%0d", c), $signed(ou_sample), $signed(prev_sample));
      if (ou_valid && ou_ready) begin
        check($sformatf("stall_order[%0d]", out_idx), $signed(ou_sample), (out_idx + 1) * 100);
        out_idx++;
      end
      prev_stalled = ou_valid && !ou_ready;
      prev_sample  = ou_sample;
      if (in_valid && in_ready) acc_idx++;
      tick();
    end
    check("stall_out_count", out_idx, 10);
    check("stall_in_count", acc_idx, 10);
    in_valid = 1'b0;
    ou_ready = 1'b1;

`ifdef OVERDRIVE_CLIP_COUNT_EN
    push(5000, 4096, 0, 4096);
    push(1000, 4096, 0, 1470);
    push(-5000, 4096, 0, -4096);
    push(2048, 4096, 0, 2816);
    push(9000, 4096, 1, 4096);
    flush("clip");
    check("clip_count_3", clip_count, 3);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_count_clr", clip_count, 0);
`endif

    // Fill the pipe, then reset with beats in flight.
    in_valid  = 1'b1;
    in_sample = 2048;
    gain      = 16'd4096;
    mode      = 1'b0;
    tick();
    tick();
    tick();
    check("pre_reset_ou_valid", ou_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_ou_valid", ou_valid, 0);
    check("mid_reset_ou_sample", $signed(ou_sample), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    push(-2048, 4096, 0, -2816);
    flush("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
